// File: rtl/add_sub_pipe.sv
// add_sub_pipe: LAT-stage unsigned add/subtract pipeline with wrap or saturate mode, overflow flag and tag passthrough.
// Latency: a beat accepted at edge k shows out_valid=1 after edge k+LAT-1. Throughput is 1 beat/cycle.
// Backpressure: stages advance only into free slots, so bubbles collapse. in_ready drops when all LAT stages hold beats and out_ready=0.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; a beat is accepted when both are 1
//   op, a, b, in_tag      0: a+b, 1: a-b; operands; opaque tag
//   out_valid/out_ready   result handshake; a beat is released when both are 1
//   y, ovf, out_tag       result, carry/borrow flag, returned tag
//   occupancy             number of beats currently held (0..LAT)
module add_sub_pipe #(
  parameter int W   = 8,
  parameter int LAT = 2,
  parameter int TW  = 4,
  parameter int SAT = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       op,
  input  logic [W-1:0]               a,
  input  logic [W-1:0]               b,
  input  logic [TW-1:0]              in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               y,
  output logic                       ovf,
  output logic [TW-1:0]              out_tag,
  output logic [$clog2(LAT+1)-1:0]   occupancy
);

  localparam int OW = $clog2(LAT+1);

  // Index 0 is the input stage; index LAT-1 drives the outputs.
  logic [LAT-1:0]         r_vld;
  logic [LAT-1:0][W-1:0]  r_y;
  logic [LAT-1:0]         r_ovf;
  logic [LAT-1:0][TW-1:0] r_tag;
  logic [OW-1:0]          r_occ;

  logic [LAT-1:0]         w_adv;
  logic                   w_acc;
  logic                   w_rel;
  logic [W:0]             w_sum;
  logic [W:0]             w_dif;
  logic                   w_ovf1;
  logic [W-1:0]           w_y1;

  // A stage may load when it, or any stage downstream of it, has a free slot,
  // or when the output is being drained. This lets a stalled pipe fill bubbles.
  for (genvar gi = 0; gi < LAT; gi++) begin : g_adv
    assign w_adv[gi] = out_ready | ~(&r_vld[LAT-1:gi]);
  end

  assign in_ready  = rst_n & w_adv[0];
  assign w_acc     = in_valid & in_ready;
  assign w_rel     = r_vld[LAT-1] & out_ready;

  assign out_valid = r_vld[LAT-1];
  assign y         = r_y[LAT-1];
  assign ovf       = r_ovf[LAT-1];
  assign out_tag   = r_tag[LAT-1];
  assign occupancy = r_occ;

  // W+1 bit arithmetic. For subtraction, bit W is the borrow, which is set exactly when a<b.
  assign w_sum = {1'b0, a} + {1'b0, b};
  assign w_dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_ovf1 = op ? w_dif[W] : w_sum[W];
    w_y1   = op ? w_dif[W-1:0] : w_sum[W-1:0];
    if ((SAT != 0) && w_ovf1) begin
      w_y1 = op ? '0 : '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_y   <= '0;
      r_ovf <= '0;
      r_tag <= '0;
      r_occ <= '0;
    end else begin
      if (w_adv[0]) begin
        r_vld[0] <= w_acc;
        // Payload only moves with a real beat. This keeps the outputs quiet across bubbles.
        if (w_acc) begin
          r_y[0]   <= w_y1;
          r_ovf[0] <= w_ovf1;
          r_tag[0] <= in_tag;
        end
      end
      for (int i = 1; i < LAT; i++) begin
        if (w_adv[i]) begin
          r_vld[i] <= r_vld[i-1];
          if (r_vld[i-1]) begin
            r_y[i]   <= r_y[i-1];
            r_ovf[i] <= r_ovf[i-1];
            r_tag[i] <= r_tag[i-1];
          end
        end
      end
      case ({w_acc, w_rel})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_pipe.sv
// tb_add_sub_pipe: exercises a wrap instance and a saturate instance (LAT=3) driven in lockstep.
// Latency: the expected results are queued when a beat is accepted and are popped when it is released.
// Backpressure: out_ready is driven by the tests to stall and release the pipe.
module tb_add_sub_pipe;

  typedef struct packed {
    logic [7:0] y0;
    logic       ovf;
    logic [7:0] y1;
    logic [3:0] tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       op = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [3:0] in_tag = '0;
  logic       out_ready = 1'b0;

  logic [1:0] in_ready;
  logic [1:0] out_valid;
  logic [1:0] ovf;
  logic [7:0] y [2];
  logic [3:0] out_tag [2];
  logic [1:0] occ [2];

  int checks = 0;
  int errors = 0;
  int n_rel  = 0;
  exp_t sb[$];

  logic       held;
  logic [7:0] h_y;
  logic       h_ovf;
  logic [3:0] h_tag;
  logic [2:0] ah;
  logic [2:0] rh;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    add_sub_pipe #(.W(8), .LAT(3), .TW(4), .SAT(gi)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[gi]),
      .op(op), .a(a), .b(b), .in_tag(in_tag),
      .out_valid(out_valid[gi]), .out_ready(out_ready),
      .y(y[gi]), .ovf(ovf[gi]), .out_tag(out_tag[gi]), .occupancy(occ[gi])
    );
  end

  function automatic exp_t model(input logic [7:0] fa, input logic [7:0] fb,
                                 input logic fop, input logic [3:0] ftag);
    exp_t e;
    int   r;
    r     = fop ? (int'(fa) - int'(fb)) : (int'(fa) + int'(fb));
    e.ovf = fop ? (fa < fb) : (r > 255);
    e.y0  = r[7:0];
    e.y1  = e.ovf ? (fop ? 8'h00 : 8'hff) : r[7:0];
    e.tag = ftag;
    return e;
  endfunction

  // Monitor: samples on the falling edge, which reflects what the next rising edge will do.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      held = 1'b0;
      ah   = '0;
      rh   = '0;
    end else begin
      checks++;
      if (occ[0] > 2'd3 || occ[1] > 2'd3 || occ[0] !== occ[1]) begin
        errors++;
        $display("FAIL occ_bound occ0=%0d occ1=%0d max=3", occ[0], occ[1]);
      end
      if (ah[2] && (&rh)) begin
        checks++;
        if (out_valid[0] !== 1'b1) begin
          errors++;
          $display("FAIL latency out_valid=%b expected 1 three cycles after accept", out_valid[0]);
        end
      end
      if (held && out_valid[0]) begin
        checks++;
        if (y[0] !== h_y || ovf[0] !== h_ovf || out_tag[0] !== h_tag) begin
          errors++;
          $display("FAIL stall_hold y=%0d ovf=%b tag=%0d expected y=%0d ovf=%b tag=%0d",
                   y[0], ovf[0], out_tag[0], h_y, h_ovf, h_tag);
        end
      end
      held  = out_valid[0] && !out_ready;
      h_y   = y[0];
      h_ovf = ovf[0];
      h_tag = out_tag[0];
      if (out_valid[0] && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out tag=%0d expected no beat", out_tag[0]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_rel++;
          if (y[0] !== e.y0 || ovf[0] !== e.ovf || y[1] !== e.y1 || ovf[1] !== e.ovf ||
              out_tag[0] !== e.tag || out_tag[1] !== e.tag || out_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL sb_result got y0=%0d y1=%0d ovf=%b%b tag=%0d expected y0=%0d y1=%0d ovf=%b tag=%0d",
                     y[0], y[1], ovf[0], ovf[1], out_tag[0], e.y0, e.y1, e.ovf, e.tag);
          end
        end
      end
      if (in_valid && in_ready[0]) sb.push_back(model(a, b, op, in_tag));
      ah = {ah[1:0], in_valid && in_ready[0]};
      rh = {rh[1:0], out_ready};
    end
  end

  // Called at posedge+1. Presents one beat, returns at posedge+1 right after it is accepted, and leaves in_valid low.
  task automatic send(input logic [7:0] sa, input logic [7:0] sb_, input logic sop, input logic [3:0] stag);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; a = sa; b = sb_; op = sop; in_tag = stag;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready[0]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout tag=%0d in_ready=0 expected accept within 40 cycles", stag);
    end
  endtask

  task automatic drain(input int exp_n, input int start_rel, input string nm);
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0 || (n_rel - start_rel) != exp_n) begin
      errors++;
      $display("FAIL %s released=%0d pending=%0d expected released=%0d pending=0",
               nm, n_rel - start_rel, sb.size(), exp_n);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1; a = 8'd9; b = 8'd9; in_tag = 4'd1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0 || occ[0] !== 2'd0) begin
        errors++;
        $display("FAIL reset in_ready=%b out_valid=%b occ=%0d expected 0 0 0",
                 in_ready[0], out_valid[0], occ[0]);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (occ[0] !== 2'd0 || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL post_reset occ=%0d out_valid=%b in_ready=%b expected 0 0 1",
               occ[0], out_valid[0], in_ready[0]);
    end
    @(posedge clk); #1;
  endtask

  // Checks that the beat is absent for two falling edges and present on the third, with the expected values.
  task automatic check_latency(input string nm, input logic [7:0] ey, input logic eovf, input logic [3:0] etag);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL %s_early out_valid=1 at cycle %0d expected 0", nm, i);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b1 || y[0] !== ey || ovf[0] !== eovf || out_tag[0] !== etag) begin
      errors++;
      $display("FAIL %s out_valid=%b y=%0d ovf=%b tag=%0d expected 1 y=%0d ovf=%b tag=%0d",
               nm, out_valid[0], y[0], ovf[0], out_tag[0], ey, eovf, etag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    send(8'd200, 8'd100, 1'b0, 4'd5);
    check_latency("wrap_add", 8'd44, 1'b1, 4'd5);
    send(8'd30, 8'd12, 1'b1, 4'd6);
    check_latency("wrap_sub", 8'd18, 1'b0, 4'd6);
  endtask

  task automatic test_saturate();
    logic [7:0] va [3] = '{8'd200, 8'd10, 8'd100};
    logic [7:0] vb [3] = '{8'd100, 8'd20, 8'd27};
    logic       vo [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] ey [3] = '{8'd255, 8'd0, 8'd127};
    logic       ev [3] = '{1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bit ok;
      ok = 1'b0;
      send(va[k], vb[k], vo[k], 4'(k + 8));
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (out_valid[1]) begin
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!ok || y[1] !== ey[k] || ovf[1] !== ev[k]) begin
        errors++;
        $display("FAIL sat_%0d valid=%b y=%0d ovf=%b expected 1 y=%0d ovf=%b",
                 k, out_valid[1], y[1], ovf[1], ey[k], ev[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int r0;
    r0 = n_rel;
    out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) send(8'(t * 40), 8'(t * 7), t[0], 4'(t));
    in_valid = 1'b1; a = 8'd160; b = 8'd28; op = 1'b0; in_tag = 4'd4;
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b0 || occ[0] !== 2'd3) begin
      errors++;
      $display("FAIL bp_full in_ready=%b occ=%0d expected 0 3", in_ready[0], occ[0]);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'd160, 8'd28, 1'b0, 4'd4);
    send(8'd200, 8'd35, 1'b1, 4'd5);
    drain(5, r0, "bp_drain");
  endtask

  task automatic test_bubble();
    int r0;
    r0 = n_rel;
    out_ready = 1'b0;
    send(8'd1, 8'd2, 1'b0, 4'd1);
    @(posedge clk); #1;
    send(8'd3, 8'd4, 1'b0, 4'd2);
    send(8'd5, 8'd9, 1'b1, 4'd3);
    @(negedge clk);
    checks++;
    if (occ[0] !== 2'd3 || in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL bubble_full occ=%0d in_ready=%b expected 3 0", occ[0], in_ready[0]);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain(3, r0, "bubble_drain");
  endtask

  task automatic test_reset_mid();
    int r0;
    out_ready = 1'b0;
    send(8'd1, 8'd2, 1'b0, 4'd11);
    send(8'd4, 8'd5, 1'b0, 4'd12);
    @(posedge clk); #1;
    checks++;
    if (out_valid[0] !== 1'b1 || occ[0] !== 2'd2) begin
      errors++;
      $display("FAIL mid_before out_valid=%b occ=%0d expected 1 2", out_valid[0], occ[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || occ[0] !== 2'd0 || in_ready[0] !== 1'b0 || y[0] !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset out_valid=%b occ=%0d in_ready=%b y=%0d expected 0 0 0 0",
               out_valid[0], occ[0], in_ready[0], y[0]);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    r0 = n_rel;
    out_ready = 1'b1;
    send(8'd50, 8'd60, 1'b0, 4'd13);
    check_latency("mid_after", 8'd110, 1'b0, 4'd13);
    drain(1, r0, "mid_drain");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_backpressure();
    test_bubble();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_pending pending=%0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
